wiscsc15_fetch: RTL and testbench
=================================

Name: wiscsc15_fetch

Overview:
Instruction-fetch stage for WISC-SC15, directly upstream of wiscsc15_ctrl. It owns the PC and issues word reads to instruction memory over a variable-latency req/rdy handshake. It captures each returned instruction into the IF/ID register, whose if_opcode field drives the control unit's Opcode input. It also handles downstream stall, branch/call/ret redirect with squash of in-flight fetches, and a one-entry skid buffer.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
AW, 16, PC / instruction address width (word-addressed).

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
imem_req  out  1  fetch request; held until imem_rdy sampled high.
imem_addr  out  AW  fetch address; stable while imem_req high.
imem_rdy  in  1  response valid this cycle; may assert in the first req cycle.
imem_rdata  in  16  instruction word, valid with imem_rdy.
id_stall  in  1  downstream cannot accept; IF/ID must hold.
redirect_valid  in  1  one-cycle pulse: flush and fetch from redirect_pc (branch taken, call, ret).
redirect_pc  in  AW  redirect target.
if_valid  out  1  IF/ID holds a live instruction.
if_instr  out  16  IF/ID instruction.
if_opcode  out  4  if_instr[15:12]; drives the control unit's Opcode input.
if_pc  out  AW  address of if_instr.
if_pc_plus1  out  AW  if_pc+1 (return address for call), wraps modulo 2^AW.
halted  out  1  fetch stopped (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus1=0, skid buffer empty, halted=0.
- Consumption: IF/ID is consumed on any cycle with if_valid && !id_stall.
- imem_req is combinational from state: 1 in S_REQ and S_DROP, 0 otherwise. imem_addr = pc in S_REQ; the latched squashed address in S_DROP.
- States:
  - S_IDLE: first cycle after reset release; go to S_REQ.
  - S_REQ, no redirect, imem_rdy=1: if IF/ID is free or being consumed, load IF/ID {instr, pc, pc+1}, set if_valid=1, pc<=pc+1, stay in S_REQ. Otherwise load the skid buffer, pc<=pc+1, go to S_HOLD.
  - S_REQ, imem_rdy=0: no change. If IF/ID is consumed, clear if_valid.
  - S_HOLD: imem_req=0. When id_stall drops, skid contents move to IF/ID; go to S_REQ.
  - S_DROP: imem_req held at the old address. On imem_rdy, discard the data and go to S_REQ with pc already = redirect target.
- Redirect has highest priority and wins over stall, rdy and hold:
  - Always: if_valid<=0, skid cleared, pc<=redirect_pc.
  - From S_REQ: if imem_rdy is also high, discard the data and stay in S_REQ. If not, go to S_DROP; the squashed request is never abandoned mid-handshake.
  - From S_HOLD/S_IDLE: go to S_REQ.
  - From S_DROP: retarget pc only; stay in S_DROP.
- Latency: a single-cycle-rdy memory delivers one instruction per cycle; IF/ID updates on the edge where imem_rdy is sampled.
- Throughput and ordering: no instruction is ever lost or duplicated across stall; at most one request is outstanding.
- Wrap: pc 16'hFFFF increments to 16'h0000.
- Reset mid-request: the outstanding handshake is abandoned. The memory must tolerate req dropping.

Optional Feature:
WISCSC15_HLT_EN.
- Defined: a captured instruction with opcode 4'b1111 is passed to IF/ID normally. The same edge enters S_HALT: imem_req=0, halted=1, pc frozen. Only reset or redirect_valid leaves S_HALT.
- Undefined: opcode 4'b1111 is fetched like any other instruction, S_HALT does not exist, and halted is tied 0.

Test Plan:
1. Reset, then 1-cycle memory returning 16'h0123, 16'h4567, 16'h89AB at addresses 0,1,2 -> IF/ID shows pc 0,1,2 on consecutive cycles, if_opcode=0,4,8, if_pc_plus1=1,2,3.
2. Hold id_stall=1 for 3 cycles while rdy returns the instruction at addr 5 -> state S_HOLD, imem_req=0, IF/ID unchanged. On release, addr 5 appears in IF/ID next cycle and fetch resumes at addr 6.
3. Memory latency 3; redirect_valid to 16'h0040 one cycle after a req to 16'h0010 -> imem_addr stays 16'h0010 until rdy, that data is discarded, and the next req is 16'h0040 with if_valid=0 meanwhile.
4. redirect_valid and imem_rdy in the same cycle with id_stall=1 -> IF/ID and skid flushed, next imem_addr=redirect_pc, no stale instruction reaches IF/ID.
5. Fetch at pc 16'hFFFF -> if_pc=16'hFFFF, if_pc_plus1=16'h0000, next imem_addr=16'h0000.
6. (WISCSC15_HLT_EN) fetch 16'hF000 -> if_opcode=4'hF, halted=1, no further req. A redirect to 16'h0008 then clears halted and fetch resumes at 16'h0008.

Source files
------------

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch: PC, imem req/rdy handshake, IF/ID register, skid buffer, redirect squash.
// Optional halt on opcode 4'hF when WISCSC15_HLT_EN is defined.
module wiscsc15_fetch #(
    parameter int          AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rdy,
    input  logic [15:0]   imem_rdata,
    input  logic          id_stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [15:0]   if_instr,
    output logic [3:0]    if_opcode,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc_plus1,
    output logic          halted
);

    // state  | meaning
    // S_IDLE | first cycle after reset release
    // S_REQ  | request outstanding at pc
    // S_HOLD | returned word parked in skid, waiting for IF/ID to drain
    // S_DROP | squashed request still in handshake at drop_addr
    // S_HALT | halt opcode fetched, no requests (WISCSC15_HLT_EN only)
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
`ifdef WISCSC15_HLT_EN
        S_HALT,
`endif
        S_DROP
    } state_t;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] drop_addr;
    logic          skid_valid;
    logic [15:0]   skid_instr;
    logic [AW-1:0] skid_pc;
    logic          if_free;

    assign imem_req  = (state == S_REQ) || (state == S_DROP);
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;
    assign if_opcode = if_instr[15:12];
    assign if_free   = !if_valid || !id_stall;

`ifdef WISCSC15_HLT_EN
    logic halt_reg;
    assign halted = halt_reg;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            drop_addr   <= RESET_PC;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
`ifdef WISCSC15_HLT_EN
            halt_reg    <= 1'b0;
`endif
        end else begin
            if (if_valid && !id_stall)
                if_valid <= 1'b0;

            if (redirect_valid) begin
                if_valid   <= 1'b0;
                skid_valid <= 1'b0;
                pc         <= redirect_pc;
`ifdef WISCSC15_HLT_EN
                halt_reg   <= 1'b0;
`endif
                case (state)
                    S_REQ: begin
                        // a request already in handshake must complete before retargeting
                        if (!imem_rdy) begin
                            state     <= S_DROP;
                            drop_addr <= pc;
                        end
                    end
                    S_DROP:  state <= S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_IDLE: state <= S_REQ;
                    S_REQ: begin
                        if (imem_rdy) begin
                            pc <= pc + ONE;
                            if (if_free) begin
                                if_valid    <= 1'b1;
                                if_instr    <= imem_rdata;
                                if_pc       <= pc;
                                if_pc_plus1 <= pc + ONE;
`ifdef WISCSC15_HLT_EN
                                if (imem_rdata[15:12] == 4'hF) begin
                                    state    <= S_HALT;
                                    halt_reg <= 1'b1;
                                end
`endif
                            end else begin
                                skid_valid <= 1'b1;
                                skid_instr <= imem_rdata;
                                skid_pc    <= pc;
                                state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!id_stall) begin
                            if_valid    <= skid_valid;
                            if_instr    <= skid_instr;
                            if_pc       <= skid_pc;
                            if_pc_plus1 <= skid_pc + ONE;
                            skid_valid  <= 1'b0;
                            state       <= S_REQ;
`ifdef WISCSC15_HLT_EN
                            if (skid_instr[15:12] == 4'hF) begin
                                state    <= S_HALT;
                                halt_reg <= 1'b1;
                            end
`endif
                        end
                    end
                    S_DROP: begin
                        if (imem_rdy)
                            state <= S_REQ;
                    end
`ifdef WISCSC15_HLT_EN
                    S_HALT: state <= S_HALT;
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wiscsc15_fetch.sv
// Directed self-checking bench for wiscsc15_fetch with a variable-latency instruction memory model.
module tb_wiscsc15_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_rdata;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [3:0]  if_opcode;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        halted;

    int tests = 0;
    int fails = 0;
    int mem_lat = 0;
    int mem_cnt = 0;

    wiscsc15_fetch #(.AW(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
        .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h0123;
            16'h0001: return 16'h4567;
            16'h0002: return 16'h89AB;
            16'h0030: return 16'hF000;
            default:  return {4'h1, a[11:0]};
        endcase
    endfunction

    assign imem_rdy   = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_rdy) mem_cnt <= 0;
        else                       mem_cnt <= mem_cnt + 1;
    end

    task automatic do_reset(input logic redir, input logic [15:0] rpc);
        rst_n = 1'b0;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        redirect_valid = redir;
        redirect_pc = rpc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
        tests++; if ({if_valid, if_instr, if_pc, if_pc_plus1, halted} !== 50'b0) begin fails++;
            $display("FAIL rst_ifid: got v=%b i=%h pc=%h p1=%h h=%b want all 0", if_valid, if_instr, if_pc, if_pc_plus1, halted); end
        do_reset(1'b0, 16'h0000);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({imem_req, if_valid, if_pc} !== 18'b0) begin fails++;
            $display("FAIL async_rst: got req=%b v=%b pc=%h want 0 0 0000", imem_req, if_valid, if_pc); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_instr [3];
        exp_instr = '{16'h0123, 16'h4567, 16'h89AB};
        mem_lat = 0;
        do_reset(1'b0, 16'h0000);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++;
            $display("FAIL first_req: got req=%b addr=%h want 1 0000", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (if_valid !== 1'b1 || if_pc !== i[15:0] || if_instr !== exp_instr[i]) begin fails++;
                $display("FAIL stream_ifid%0d: got v=%b pc=%h i=%h want 1 %h %h", i, if_valid, if_pc, if_instr, i[15:0], exp_instr[i]); end
            tests++; if (if_opcode !== exp_instr[i][15:12] || if_pc_plus1 !== i[15:0] + 16'h1) begin fails++;
                $display("FAIL stream_op%0d: got op=%h p1=%h want %h %h", i, if_opcode, if_pc_plus1, exp_instr[i][15:12], i[15:0] + 16'h1); end
        end
    endtask

    task automatic test_stall();
        mem_lat = 0;
        do_reset(1'b0, 16'h0000);
        repeat (5) tick();
        tests++; if (if_pc !== 16'h0004 || imem_addr !== 16'h0005) begin fails++;
            $display("FAIL stall_pre: got pc=%h addr=%h want 0004 0005", if_pc, imem_addr); end
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (imem_req !== 1'b0 || if_pc !== 16'h0004 || if_valid !== 1'b1) begin fails++;
                $display("FAIL stall_hold%0d: got req=%b pc=%h v=%b want 0 0004 1", k, imem_req, if_pc, if_valid); end
        end
        id_stall = 1'b0;
        tick();
        tests++; if (if_pc !== 16'h0005 || if_instr !== 16'h1005 || if_valid !== 1'b1) begin fails++;
            $display("FAIL stall_release: got pc=%h i=%h v=%b want 0005 1005 1", if_pc, if_instr, if_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin fails++;
            $display("FAIL stall_resume_req: got req=%b addr=%h want 1 0006", imem_req, imem_addr); end
        tick();
        tests++; if (if_pc !== 16'h0006 || if_instr !== 16'h1006) begin fails++;
            $display("FAIL stall_next: got pc=%h i=%h want 0006 1006", if_pc, if_instr); end
    endtask

    task automatic test_redirect_squash();
        mem_lat = 3;
        do_reset(1'b1, 16'h0010);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin fails++;
            $display("FAIL sq_req: got req=%b addr=%h want 1 0010", imem_req, imem_addr); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || if_valid !== 1'b0) begin fails++;
                $display("FAIL sq_drop%0d: got req=%b addr=%h v=%b want 1 0010 0", k, imem_req, imem_addr, if_valid); end
            tick();
        end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || if_valid !== 1'b0) begin fails++;
            $display("FAIL sq_retarget: got req=%b addr=%h v=%b want 1 0040 0", imem_req, imem_addr, if_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (if_valid !== 1'b0) begin fails++;
                $display("FAIL sq_wait%0d: got v=%b want 0", k, if_valid); end
        end
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== 16'h1040) begin fails++;
            $display("FAIL sq_land: got v=%b pc=%h i=%h want 1 0040 1040", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_stall();
        mem_lat = 0;
        do_reset(1'b0, 16'h0000);
        repeat (3) tick();
        id_stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin fails++;
            $display("FAIL rs_flush: got v=%b req=%b addr=%h want 0 1 0020", if_valid, imem_req, imem_addr); end
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0020 || if_instr !== 16'h1020) begin fails++;
            $display("FAIL rs_target: got v=%b pc=%h i=%h want 1 0020 1020", if_valid, if_pc, if_instr); end
        tick();
        tests++; if (imem_req !== 1'b0 || if_pc !== 16'h0020) begin fails++;
            $display("FAIL rs_hold: got req=%b pc=%h want 0 0020", imem_req, if_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0050;
        tick();
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        tests++; if (if_valid !== 1'b0 || imem_addr !== 16'h0050 || imem_req !== 1'b1) begin fails++;
            $display("FAIL rs_hold_flush: got v=%b addr=%h req=%b want 0 0050 1", if_valid, imem_addr, imem_req); end
        tick();
        tests++; if (if_pc !== 16'h0050 || if_instr !== 16'h1050) begin fails++;
            $display("FAIL rs_no_stale: got pc=%h i=%h want 0050 1050", if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        mem_lat = 0;
        do_reset(1'b1, 16'hFFFF);
        tests++; if (imem_addr !== 16'hFFFF) begin fails++;
            $display("FAIL wrap_req: got addr=%h want ffff", imem_addr); end
        tick();
        tests++; if (if_pc !== 16'hFFFF || if_pc_plus1 !== 16'h0000 || if_instr !== 16'h1FFF) begin fails++;
            $display("FAIL wrap_ifid: got pc=%h p1=%h i=%h want ffff 0000 1fff", if_pc, if_pc_plus1, if_instr); end
        tests++; if (imem_addr !== 16'h0000) begin fails++;
            $display("FAIL wrap_next_addr: got %h want 0000", imem_addr); end
        tick();
        tests++; if (if_pc !== 16'h0000 || if_instr !== 16'h0123 || if_pc_plus1 !== 16'h0001) begin fails++;
            $display("FAIL wrap_after: got pc=%h i=%h p1=%h want 0000 0123 0001", if_pc, if_instr, if_pc_plus1); end
    endtask

    task automatic test_halt_opcode();
        mem_lat = 0;
        do_reset(1'b1, 16'h0030);
        tick();
        tests++; if (if_instr !== 16'hF000 || if_opcode !== 4'hF || if_pc !== 16'h0030) begin fails++;
            $display("FAIL hlt_capture: got i=%h op=%h pc=%h want f000 f 0030", if_instr, if_opcode, if_pc); end
`ifdef WISCSC15_HLT_EN
        tests++; if (halted !== 1'b1 || imem_req !== 1'b0) begin fails++;
            $display("FAIL hlt_enter: got halted=%b req=%b want 1 0", halted, imem_req); end
        tick(); tick();
        tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin fails++;
            $display("FAIL hlt_stay: got halted=%b req=%b v=%b want 1 0 0", halted, imem_req, if_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0008;
        tick();
        redirect_valid = 1'b0;
        tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0008) begin fails++;
            $display("FAIL hlt_exit: got halted=%b req=%b addr=%h want 0 1 0008", halted, imem_req, imem_addr); end
        tick();
        tests++; if (if_pc !== 16'h0008 || if_instr !== 16'h1008) begin fails++;
            $display("FAIL hlt_resume: got pc=%h i=%h want 0008 1008", if_pc, if_instr); end
`else
        tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0031) begin fails++;
            $display("FAIL f_op_normal: got halted=%b req=%b addr=%h want 0 1 0031", halted, imem_req, imem_addr); end
        tick();
        tests++; if (if_pc !== 16'h0031 || if_instr !== 16'h1031 || halted !== 1'b0) begin fails++;
            $display("FAIL f_op_next: got pc=%h i=%h halted=%b want 0031 1031 0", if_pc, if_instr, halted); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_squash();
        test_redirect_stall();
        test_wrap();
        test_halt_opcode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
